// File: rtl/mc_unified_mem_pkg.sv
// Shared definitions for the unified instruction/data memory responder.
// Holds the top-level state encodings, the word/byte widths and the default geometry.
// Contains no logic.
package mc_unified_mem_pkg;

  localparam int WORD_W          = 32;
  localparam int BYTE_W          = 8;
  localparam int DEF_DEPTH_WORDS = 4096;
  localparam int DEF_AW          = 12;

  // Memory-side system state, exported on o_mstate
  typedef enum logic [1:0] {
    MS_LOAD = 2'b00,
    MS_RUN  = 2'b01,
    MS_HALT = 2'b10
  } mstate_e;

endpackage

// File: rtl/mc_unified_mem_if.sv
// Core bus, boot loader stream and debug port bundled between the core/bench and memory.
// master = core/loader/bench side; slave = memory side (mc_unified_mem).
// Loader uses valid/ready; the core bus has no handshake (zero-wait async reads).
interface mc_unified_mem_if;
  import mc_unified_mem_pkg::*;

  // core bus
  logic [WORD_W-1:0] adr;
  logic [WORD_W-1:0] wdata;
  logic              we;
  logic [WORD_W-1:0] rdata;
  logic              core_done;
  logic              core_rst;
  // byte-serial boot loader
  logic              ld_valid;
  logic [BYTE_W-1:0] ld_byte;
  logic              ld_last;
  logic              ld_ready;
  // debug read port
  logic [WORD_W-1:0] dbg_addr;
  logic [WORD_W-1:0] dbg_data;

  modport master (
    output adr, wdata, we, core_done, ld_valid, ld_byte, ld_last, dbg_addr,
    input  rdata, core_rst, ld_ready, dbg_data
  );

  modport slave (
    input  adr, wdata, we, core_done, ld_valid, ld_byte, ld_last, dbg_addr,
    output rdata, core_rst, ld_ready, dbg_data
  );

endinterface

// File: rtl/mc_unified_mem_ram.sv
// Word RAM: one synchronous write port, two asynchronous read ports (core, debug).
// Reads are zero latency and show pre-write data in the cycle of a write to the same word.
// No backpressure. Ports: i_clk, i_we/i_waddr/i_wdata write; i_raddr_a/b -> o_rdata_a/b.
module mc_ram_1w2r
  import mc_unified_mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH_WORDS,
  parameter int AW    = DEF_AW
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr_a,
  output logic [WORD_W-1:0] o_rdata_a,
  input  logic [AW-1:0]     i_raddr_b,
  output logic [WORD_W-1:0] o_rdata_b
);

  // contents deliberately not reset: an image survives a system reset
  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/mc_unified_mem.sv
// Unified I/D memory responder: boots the image byte-serially, runs the core, halts on done.
// Core and debug reads are combinational; loader words are written on the 4th or last byte.
// Loader is accepted every cycle while in LOAD (ld_ready=1), never otherwise.
// Ports: i_clk, i_rst (sync, high), bus (slave), o_mstate, sticky o_err_oob/misalign/ld_ovf.
module mc_unified_mem
  import mc_unified_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int AW          = DEF_AW
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mc_unified_mem_if.slave    bus,
  output logic [1:0]         o_mstate,
  output logic               o_err_oob,
  output logic               o_err_misalign,
  output logic               o_err_ld_ovf
);

  mstate_e            r_state;
  mstate_e            w_state_nxt;
  logic [AW:0]        r_ptr;       // one extra bit so the pointer can sit at DEPTH_WORDS
  logic [1:0]         r_idx;
  logic [23:0]        r_asm;       // bytes 0..2 of the word under assembly
  logic               r_err_oob;
  logic               r_err_mis;
  logic               r_err_ovf;

  logic               w_run;
  logic               w_ld_xfer;
  logic               w_ld_flush;
  logic               w_ptr_ok;
  logic [WORD_W-1:0]  w_ld_word;
  logic               w_core_oob;
  logic               w_core_mis;
  logic               w_core_we;
  logic               w_dbg_oob;
  logic               w_ram_we;
  logic [AW-1:0]      w_ram_waddr;
  logic [WORD_W-1:0]  w_ram_wdata;
  logic [WORD_W-1:0]  w_core_word;
  logic [WORD_W-1:0]  w_dbg_word;
  logic               w_core_rst;
  logic               w_ld_ready;
  logic               w_unused_dbg_lsb;

  assign w_run      = (r_state == MS_RUN);
  assign w_ld_xfer  = bus.ld_valid && (r_state == MS_LOAD);
  assign w_ld_flush = w_ld_xfer && ((r_idx == 2'd3) || bus.ld_last);
  assign w_ptr_ok   = (r_ptr < (AW+1)'(DEPTH_WORDS));

  // bytes above the current index are still zero in r_asm, which zero-fills a short last word
  assign w_ld_word  = {8'h00, r_asm} | ({24'h000000, bus.ld_byte} << {r_idx, 3'b000});

  assign w_core_oob = |bus.adr[WORD_W-1:AW+2];
  assign w_core_mis = |bus.adr[1:0];
  assign w_core_we  = w_run && bus.we && !w_core_oob;
  assign w_dbg_oob  = |bus.dbg_addr[WORD_W-1:AW+2];
  assign w_unused_dbg_lsb = ^bus.dbg_addr[1:0];

  // single write port: loader owns it in LOAD, core in RUN, nobody in HALT
  assign w_ram_we    = (w_ld_flush && w_ptr_ok) || w_core_we;
  assign w_ram_waddr = w_run ? bus.adr[AW+1:2] : r_ptr[AW-1:0];
  assign w_ram_wdata = w_run ? bus.wdata : w_ld_word;

  mc_ram_1w2r #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .i_clk     (i_clk),
    .i_we      (w_ram_we),
    .i_waddr   (w_ram_waddr),
    .i_wdata   (w_ram_wdata),
    .i_raddr_a (bus.adr[AW+1:2]),
    .o_rdata_a (w_core_word),
    .i_raddr_b (bus.dbg_addr[AW+1:2]),
    .o_rdata_b (w_dbg_word)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_core_rst  = 1'b1;
    w_ld_ready  = 1'b0;
    case (r_state)
      MS_LOAD: begin
        w_ld_ready = 1'b1;
        if (w_ld_xfer && bus.ld_last) w_state_nxt = MS_RUN;
      end
      MS_RUN: begin
        w_core_rst = 1'b0;
        if (bus.core_done) w_state_nxt = MS_HALT;
      end
      MS_HALT: w_state_nxt = MS_HALT;
      default: w_state_nxt = MS_LOAD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= MS_LOAD;
      r_ptr     <= '0;
      r_idx     <= 2'd0;
      r_asm     <= 24'h000000;
      r_err_oob <= 1'b0;
      r_err_mis <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_xfer) begin
        if (!w_ptr_ok) r_err_ovf <= 1'b1;
        if (w_ld_flush) begin
          r_asm <= 24'h000000;
          r_idx <= 2'd0;
          if (w_ptr_ok) r_ptr <= r_ptr + (AW+1)'(1);  // saturates at DEPTH_WORDS
        end else begin
          r_asm <= w_ld_word[23:0];
          r_idx <= r_idx + 2'd1;
        end
      end
      // every RUN cycle is a core access (fetch or load/store)
      if (w_run && w_core_oob) r_err_oob <= 1'b1;
      if (w_run && w_core_mis) r_err_mis <= 1'b1;
    end
  end

  assign bus.rdata    = ((r_state != MS_HALT) && !w_core_oob) ? w_core_word : '0;
  assign bus.dbg_data = w_dbg_oob ? '0 : w_dbg_word;
  assign bus.core_rst = w_core_rst;
  assign bus.ld_ready = w_ld_ready;

  assign o_mstate       = r_state;
  assign o_err_oob      = r_err_oob;
  assign o_err_misalign = r_err_mis;
  assign o_err_ld_ovf   = r_err_ovf;

endmodule
